// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit add/subtract: the carry chain is cut into STAGES equal segments with a
// register between segments, a valid/ready handshake with backpressure, and a synchronous flush.
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int W   = N / STAGES;
    localparam int L   = STAGES - 1;
    localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;

    if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_add_sub: need N >= 2, 1 <= STAGES <= N and N %% STAGES == 0");
    end

    logic         stall;
    logic         c0;
    logic [W:0]   seg;

    // Per-stage view: x carries finished low sum segments plus not-yet-added upper bits of a,
    // y carries the conditioned b; both move down the pipe together.
    logic [N-1:0] x_in [STAGES];
    logic [N-1:0] y_in [STAGES];
    logic         c_in [STAGES];
    logic         v_in [STAGES];
    logic [N-1:0] x_d  [STAGES];
    logic         c_d  [STAGES];

    logic [N-1:0] x_q  [MID];
    logic [N-1:0] y_q  [MID];
    logic         c_q  [MID];
    logic         v_q  [MID];
    logic         v_d  [MID];

    logic [N-1:0] sum_d, sum_q;
    logic         cout_d, cout_q;
    logic         ovf_d, ovf_q;
    logic         zero_d, zero_q;
    logic         neg_d, neg_q;
    logic         out_valid_d, out_valid_q;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

    always_comb begin
        unique case (op)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = 1'b1;
            default: c0 = cin;
        endcase
    end

    always_comb begin
        x_in[0] = a;
        y_in[0] = b ^ {N{op[0]}};
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            x_in[k] = x_q[k-1];
            y_in[k] = y_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        seg = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg = {1'b0, x_in[k][k*W +: W]} + {1'b0, y_in[k][k*W +: W]} + {{W{1'b0}}, c_in[k]};
            x_d[k] = x_in[k];
            x_d[k][k*W +: W] = seg[W-1:0];
            c_d[k] = seg[W];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < MID; k++) begin
            v_d[k] = flush ? 1'b0 : (stall ? v_q[k] : v_in[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MID; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < MID; k++) begin
                v_q[k] <= v_d[k];
                if (!stall) begin
                    x_q[k] <= x_d[k];
                    y_q[k] <= y_in[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    always_comb begin
        sum_d       = x_d[L];
        cout_d      = c_d[L];
        ovf_d       = (sum_d[N-1] ^ x_in[L][N-1] ^ y_in[L][N-1]) ^ cout_d;
        zero_d      = (sum_d == '0);
        neg_d       = sum_d[N-1];
        out_valid_d = flush ? 1'b0 : (stall ? out_valid_q : v_in[L]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (!stall) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations (32/4, 32/1, 8/8) share one stimulus stream
// and are checked every cycle against a slot-delay model built on plain integer arithmetic.
module tb_pipelined_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = 2'b00;

    logic [2:0]  ov, ir, co, of, zr, ng;
    logic [31:0] sm0, sm1;
    logic [7:0]  sm8;

    int checks = 0;
    int failures = 0;
    int deliv [3] = '{0, 0, 0};
    int lat   [3] = '{4, 1, 8};
    int wid   [3] = '{32, 32, 8};

    logic        mv [3][8];
    logic [35:0] mr [3][8];

    always #5 clk = ~clk;

    pipelined_add_sub #(.N(32), .STAGES(4)) u_main (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .neg(ng[0]));

    pipelined_add_sub #(.N(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .neg(ng[1]));

    pipelined_add_sub #(.N(8), .STAGES(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a[7:0]), .b(b[7:0]), .op(op), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
        .sum(sm8), .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .neg(ng[2]));

    // Reference arithmetic: wide integer add, signed overflow from operand/result signs.
    function automatic logic [35:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] o, input logic ci, input int w);
        longint unsigned m, xa, ya, full, s;
        logic c, cy, sx, sy, ss;
        m    = (64'd1 << w) - 64'd1;
        xa   = {32'h0, x} & m;
        ya   = (o[0] ? {32'h0, ~y} : {32'h0, y}) & m;
        c    = (o == 2'b00) ? 1'b0 : ((o == 2'b01) ? 1'b1 : ci);
        full = xa + ya + {63'h0, c};
        s    = full & m;
        cy   = full[w];
        sx   = xa[w-1];
        sy   = ya[w-1];
        ss   = s[w-1];
        return {s[31:0], cy, (sx == sy) && (ss != sx), (s == 64'h0), ss};
    endfunction

    function automatic logic [35:0] act_res(input int d);
        case (d)
            0:       return {sm0, co[0], of[0], zr[0], ng[0]};
            1:       return {sm1, co[1], of[1], zr[1], ng[1]};
            default: return {24'h0, sm8, co[2], of[2], zr[2], ng[2]};
        endcase
    endfunction

    // Each configuration is a chain of lat slots that advances unless its last slot is stalled.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                for (int s = 0; s < 8; s++) mv[d][s] <= 1'b0;
            end else if (flush) begin
                for (int s = 0; s < 8; s++) mv[d][s] <= 1'b0;
            end else if (!(mv[d][lat[d]-1] && !out_ready)) begin
                for (int s = 7; s > 0; s--) begin
                    mv[d][s] <= mv[d][s-1];
                    mr[d][s] <= mr[d][s-1];
                end
                mv[d][0] <= in_valid;
                mr[d][0] <= ref_res(a, b, op, cin, wid[d]);
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h", nm, d, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        logic        ev;
        logic [35:0] er;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                ev = mv[d][lat[d]-1];
                er = mr[d][lat[d]-1];
                chk("out_valid", d, 40'(ov[d]), 40'(ev));
                chk("in_ready", d, 40'(ir[d]), 40'(!(ev && !out_ready)));
                if (ev) begin
                    chk("result", d, {4'h0, act_res(d)}, {4'h0, er});
                    if (out_ready) deliv[d]++;
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        cmp_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic vec(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                       input logic vcin, input logic [35:0] e32, input logic chk8,
                       input logic [11:0] e8);
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a = va; b = vb; op = vop; cin = vcin;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            settle();
            if (c == 1) chk("vec_lat1", 1, {3'b0, ov[1], act_res(1)}, {4'b0001, e32});
            if (c == 4) chk("vec_lat4", 0, {3'b0, ov[0], act_res(0)}, {4'b0001, e32});
            if (c == 8 && chk8) chk("vec_w8", 2, {3'b0, ov[2], act_res(2)}, {4'b0001, 24'h0, e8});
            adv();
        end
    endtask

    initial begin
        int idx, d0, d2;
        logic acc;
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic [1:0]  sop [8];
        logic        sc [8];

        #1 rst_n = 1'b0;
        #3;
        for (int d = 0; d < 3; d++)
            chk("reset_state", d, {2'b0, ov[d], ir[d], act_res(d)}, {2'b0, 1'b0, 1'b1, 36'h0});
        #8 rst_n = 1'b1;
        adv();

        vec(32'h0000_FFFF, 32'h1, 2'b00, 1'b0, {32'h0001_0000, 4'b0000}, 1'b0, 12'h0);
        vec(32'h8000_0000, 32'h1, 2'b01, 1'b0, {32'h7FFF_FFFF, 4'b1100}, 1'b0, 12'h0);
        vec(32'h5, 32'h5, 2'b01, 1'b0, {32'h0, 4'b1010}, 1'b0, 12'h0);
        vec(32'hFFFF_FFFF, 32'h0, 2'b10, 1'b1, {32'h0, 4'b1010}, 1'b0, 12'h0);
        vec(32'h0, 32'h0, 2'b11, 1'b0, {32'hFFFF_FFFF, 4'b0001}, 1'b0, 12'h0);
        vec(32'h3, 32'h5, 2'b01, 1'b0, {32'hFFFF_FFFE, 4'b0001}, 1'b0, 12'h0);
        vec(32'h7F, 32'h1, 2'b00, 1'b0, {32'h80, 4'b0000}, 1'b1, {8'h80, 4'b0101});

        // Back-to-back stream with a downstream stall window.
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sop[i] = 2'($urandom_range(0, 3)); sc[i] = 1'($urandom);
        end
        d0 = deliv[0];
        idx = 0;
        for (int i = 0; i < 24; i++) begin
            out_ready = !(i >= 6 && i <= 9);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = sa[idx]; b = sb[idx]; op = sop[idx]; cin = sc[idx];
            end
            acc = in_valid && !(mv[0][3] && !out_ready);
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 0, 40'(deliv[0] - d0), 40'd8);

        // Flush with three beats in flight; the beat offered alongside flush is dropped.
        d0 = deliv[0]; d2 = deliv[2];
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            flush = (i == 3);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("flush_clear", 0, 40'(ov), 40'd0);
        adv();
        for (int i = 0; i < 12; i++) tick();
        chk("flush_drop", 0, 40'(deliv[0] - d0), 40'd0);
        chk("flush_drop", 2, 40'(deliv[2] - d2), 40'd0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            chk("async_reset", d, {2'b0, ov[d], ir[d], act_res(d)}, {2'b0, 1'b0, 1'b1, 36'h0});
        #10 rst_n = 1'b1;
        adv();
        d0 = deliv[0]; d2 = deliv[2];
        for (int i = 0; i < 12; i++) tick();
        chk("reset_empty", 0, 40'(deliv[0] - d0), 40'd0);
        chk("reset_empty", 2, 40'(deliv[2] - d2), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
